// File: rtl/star_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : star_motion_ctrl
//  Description : Star sprite motion sequencer. Detects the start of vertical
//                blanking from the sync counters, divides frames down to a
//                position-update rate, steps the star's top-left corner with
//                edge bounce, and blinks the sprite for a number of frames
//                after each bounce. Position outputs only change a few clocks
//                after blanking starts, so a visible frame never sees a torn
//                position.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   pixel-domain clock
//    reset        in   1   synchronous, active-high
//    HCount       in  10   horizontal pixel counter
//    VCount       in  10   vertical line counter
//    enable       in   1   1 = motion runs, 0 = freeze position and divider
//    star_x_l     out 10   committed left edge of the star
//    star_y_t     out 10   committed top edge of the star
//    star_visible out  1   blink gate for star_on
//    frame_tick   out  1   one-cycle pulse per frame (start of blanking)
//    bounce       out  2   one-cycle pulse at commit; [0]=x edge, [1]=y edge
//    busy         out  1   high while the update sequence is running
// ============================================================================
module star_motion_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int STAR_W       = 200,
  parameter int STAR_H       = 150,
  parameter int X_INIT       = 430,
  parameter int Y_INIT       = 325,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 1,
  parameter int FRAME_DIV    = 1,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       enable,
  output logic [9:0] star_x_l,
  output logic [9:0] star_y_t,
  output logic       star_visible,
  output logic       frame_tick,
  output logic [1:0] bounce,
  output logic       busy
);

  // Limits and steps are held in 11 bits so x+STEP never wraps.
  localparam logic [10:0] c_XMAX      = 11'(H_ACTIVE - STAR_W);
  localparam logic [10:0] c_YMAX      = 11'(V_ACTIVE - STAR_H);
  localparam logic [10:0] c_STEP_X    = 11'(STEP_X);
  localparam logic [10:0] c_STEP_Y    = 11'(STEP_Y);
  localparam logic [9:0]  c_X_INIT    = 10'(X_INIT);
  localparam logic [9:0]  c_Y_INIT    = 10'(Y_INIT);
  localparam logic [9:0]  c_V_BLANK   = 10'(V_ACTIVE);
  localparam logic [7:0]  c_DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [7:0]  c_BLINK     = 8'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_cond_d;
  logic        r_frame_tick;
  logic [7:0]  r_div;
  logic [7:0]  r_blink;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_nx;
  logic [9:0]  r_ny;
  logic        r_dir_x_neg;
  logic        r_dir_y_neg;
  logic        r_bx;
  logic        r_by;
  logic [1:0]  r_bounce;

  logic        w_cond;
  logic        w_launch;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic        w_bx;
  logic        w_by;

  // --------------------------------------------------------------------------
  // Frame detect: the sync counters may dwell on (0, V_ACTIVE) for several
  // clocks, so only the rising edge of the condition produces a tick.
  // --------------------------------------------------------------------------
  assign w_cond = (VCount == c_V_BLANK) && (HCount == 10'd0);

  // Ticks arriving mid-sequence are dropped for launch purposes and do not
  // advance the divider; they still age the blink counter below.
  assign w_launch = r_frame_tick && enable && (r_state == S_IDLE)
                    && (r_div == c_DIV_LAST);

  // --------------------------------------------------------------------------
  // Next-position arithmetic with edge clamp. Hitting the edge exactly counts
  // as a bounce, so the star never sits on an edge heading outward.
  // --------------------------------------------------------------------------
  always_comb begin
    w_x_ext = {1'b0, r_x};
    w_y_ext = {1'b0, r_y};
    w_nx    = r_x;
    w_ny    = r_y;
    w_bx    = 1'b0;
    w_by    = 1'b0;

    if (!r_dir_x_neg) begin
      if ((w_x_ext + c_STEP_X) >= c_XMAX) begin
        w_nx = c_XMAX[9:0];
        w_bx = 1'b1;
      end else begin
        w_nx = 10'(w_x_ext + c_STEP_X);
      end
    end else begin
      if (w_x_ext <= c_STEP_X) begin
        w_nx = 10'd0;
        w_bx = 1'b1;
      end else begin
        w_nx = 10'(w_x_ext - c_STEP_X);
      end
    end

    if (!r_dir_y_neg) begin
      if ((w_y_ext + c_STEP_Y) >= c_YMAX) begin
        w_ny = c_YMAX[9:0];
        w_by = 1'b1;
      end else begin
        w_ny = 10'(w_y_ext + c_STEP_Y);
      end
    end else begin
      if (w_y_ext <= c_STEP_Y) begin
        w_ny = 10'd0;
        w_by = 1'b1;
      end else begin
        w_ny = 10'(w_y_ext - c_STEP_Y);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_state_next = S_MOVE_X;
      S_MOVE_X: w_state_next = S_MOVE_Y;
      S_MOVE_Y: w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_d     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_div        <= 8'd0;
      r_blink      <= 8'd0;
      r_x          <= c_X_INIT;
      r_y          <= c_Y_INIT;
      r_nx         <= c_X_INIT;
      r_ny         <= c_Y_INIT;
      r_dir_x_neg  <= 1'b0;
      r_dir_y_neg  <= 1'b0;
      r_bx         <= 1'b0;
      r_by         <= 1'b0;
      r_bounce     <= 2'b00;
    end else begin
      r_cond_d     <= w_cond;
      r_frame_tick <= w_cond && !r_cond_d;
      r_bounce     <= 2'b00;

      if (r_frame_tick && enable && (r_state == S_IDLE)) begin
        if (r_div == c_DIV_LAST) begin
          r_div <= 8'd0;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end

      case (r_state)
        S_MOVE_X: begin
          r_nx <= w_nx;
          r_bx <= w_bx;
          if (w_bx) r_dir_x_neg <= ~r_dir_x_neg;
        end
        S_MOVE_Y: begin
          r_ny <= w_ny;
          r_by <= w_by;
          if (w_by) r_dir_y_neg <= ~r_dir_y_neg;
        end
        S_COMMIT: begin
          r_x      <= r_nx;
          r_y      <= r_ny;
          r_bounce <= {r_by, r_bx};
        end
        default: ;
      endcase

      // A bounce reload takes priority over a same-cycle frame decrement.
      if ((r_state == S_COMMIT) && (r_bx || r_by)) begin
        r_blink <= c_BLINK;
      end else if (r_frame_tick && (r_blink != 8'd0)) begin
        r_blink <= r_blink - 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Odd blink counts hide the star, giving an on/off flash that
  // always ends in the visible state.
  // --------------------------------------------------------------------------
  assign star_x_l     = r_x;
  assign star_y_t     = r_y;
  assign star_visible = (r_blink == 8'd0) || !r_blink[0];
  assign frame_tick   = r_frame_tick;
  assign bounce       = r_bounce;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_star_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_star_motion_ctrl
//  Description : Directed self-checking bench for star_motion_ctrl. Three
//                instances share clock, reset and sync counters:
//                u0 default parameters, u1 with FRAME_DIV=3, u2 with a
//                narrow active area (XMAX=7) starting at x=3 for the left
//                edge bounce.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_star_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] hc;
  logic [9:0] vc;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       vis0, vis1, vis2;
  logic       ft0, ft1, ft2;
  logic [1:0] bn0, bn1, bn2;
  logic       busy0, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks0   = 0;
  int ticks1   = 0;

  always #5 clk = ~clk;

  star_motion_ctrl u0 (
    .clk(clk), .reset(reset), .HCount(hc), .VCount(vc), .enable(enable),
    .star_x_l(x0), .star_y_t(y0), .star_visible(vis0), .frame_tick(ft0),
    .bounce(bn0), .busy(busy0)
  );

  star_motion_ctrl #(.FRAME_DIV(3)) u1 (
    .clk(clk), .reset(reset), .HCount(hc), .VCount(vc), .enable(enable),
    .star_x_l(x1), .star_y_t(y1), .star_visible(vis1), .frame_tick(ft1),
    .bounce(bn1), .busy(busy1)
  );

  star_motion_ctrl #(.H_ACTIVE(207), .X_INIT(3)) u2 (
    .clk(clk), .reset(reset), .HCount(hc), .VCount(vc), .enable(enable),
    .star_x_l(x2), .star_y_t(y2), .star_visible(vis2), .frame_tick(ft2),
    .bounce(bn2), .busy(busy2)
  );

  always @(posedge clk) begin
    if (ft0) ticks0 <= ticks0 + 1;
    if (ft1) ticks1 <= ticks1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present the frame condition for 'hold' clocks; returns just after the
  // last posedge that sampled it.
  task automatic frame_pulse(input int hold);
    @(posedge clk); #1;
    hc = 10'd0;
    vc = 10'd480;
    repeat (hold) @(posedge clk);
    #1;
    hc = 10'd100;
    vc = 10'd100;
  endtask

  // One full frame; returns at the negedge right after the commit lands.
  task automatic run_frame();
    frame_pulse(1);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] en_tab [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
  logic [31:0] x1_exp [8] = '{430, 430, 432, 432, 432, 432, 432, 434};
  logic [31:0] x2_exp [7] = '{5, 7, 5, 3, 1, 0, 2};
  logic [31:0] y2_exp [7] = '{326, 327, 328, 329, 330, 329, 328};
  logic [31:0] b2_exp [7] = '{0, 1, 0, 0, 2, 1, 0};

  initial begin
    int t0;
    reset  = 1'b1;
    enable = 1'b1;
    hc     = 10'd100;
    vc     = 10'd100;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", x0, 430);
    check("rst_y", y0, 325);
    check("rst_vis", vis0, 1);
    check("rst_busy", busy0, 0);
    check("rst_ft", ft0, 0);
    check("rst_bounce", bn0, 0);
    reset = 1'b0;

    // ---- first frame, cycle by cycle ----
    @(posedge clk); #1;
    hc = 10'd0;
    vc = 10'd480;
    @(negedge clk);
    check("ft_not_yet", ft0, 0);
    @(posedge clk); #1;
    hc = 10'd100;
    vc = 10'd100;
    @(negedge clk);
    check("ft_high", ft0, 1);
    check("busy_at_tick", busy0, 0);
    @(posedge clk);
    @(negedge clk);
    check("ft_one_cycle", ft0, 0);
    check("busy_move_x", busy0, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("x_before_commit", x0, 430);
    check("busy_commit", busy0, 1);
    @(posedge clk);
    @(negedge clk);
    check("f1_x", x0, 432);
    check("f1_y", y0, 326);
    check("f1_busy_done", busy0, 0);

    // ---- frames 2..5, double bounce on frame 5 ----
    for (int k = 2; k <= 5; k++) begin
      run_frame();
      check("run_x", x0, 430 + 2 * k);
      check("run_y", y0, 325 + k);
      check("run_bounce", bn0, (k == 5) ? 3 : 0);
    end
    @(negedge clk);
    check("bounce_one_cycle", bn0, 0);
    check("vis_after_reload", vis0, 1);

    // ---- frames 6..14: reverse travel and blink pattern ----
    for (int k = 1; k <= 9; k++) begin
      run_frame();
      check("rev_x", x0, 440 - 2 * k);
      check("rev_y", y0, 330 - k);
      check("blink_vis", vis0, (((k % 2) == 0) || (k > 8)) ? 1 : 0);
    end

    // ---- condition held for 10 clocks ----
    t0 = ticks0;
    frame_pulse(10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_ticks", ticks0 - t0, 1);
    check("hold_x", x0, 420);
    check("hold_y", y0, 320);

    // ---- reset asserted while in MOVE_Y ----
    frame_pulse(1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("busy_move_y", busy0, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_x", x0, 430);
    check("midrst_y", y0, 325);
    check("midrst_busy", busy0, 0);
    check("midrst_bounce", bn0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_commit_x", x0, 430);
    check("no_commit_y", y0, 325);

    // ---- FRAME_DIV=3 with enable low for two frames ----
    for (int i = 0; i < 8; i++) begin
      enable = en_tab[i][0];
      t0 = ticks1;
      run_frame();
      check("div_x", x1, x1_exp[i]);
      check("div_tick", ticks1 - t0, 1);
    end
    check("u0_after_div_x", x0, 438);
    check("u0_after_div_y", y0, 329);

    // ---- enable dropped after launch: sequence still completes ----
    enable = 1'b1;
    frame_pulse(1);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("late_disable_x", x0, 436);
    check("late_disable_y", y0, 328);
    run_frame();
    check("frozen_x", x0, 436);
    check("frozen_y", y0, 328);

    // ---- left edge bounce on the narrow instance ----
    reset  = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("edge_rst_x", x2, 3);
    for (int i = 0; i < 7; i++) begin
      run_frame();
      check("edge_x", x2, x2_exp[i]);
      check("edge_y", y2, y2_exp[i]);
      check("edge_bounce", bn2, b2_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/star_motion_ctrl.md
Name: star_motion_ctrl

Overview:
- Sequences the on-screen position of the star sprite: moves the star's top-left corner once per video frame, bounces it off the active-area edges, and blinks it for a few frames after each bounce.
- Sits between the VGA sync counters (HCount/VCount) and the star object/ROM datapath.
- Position outputs change only during vertical blanking, so a frame is never drawn with a torn position.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- STAR_W, 200, star bitmap width
- STAR_H, 150, star bitmap height
- X_INIT, 430, reset value of star_x_l
- Y_INIT, 325, reset value of star_y_t
- STEP_X, 2, horizontal pixels moved per update (1..H_ACTIVE-STAR_W-1)
- STEP_Y, 1, vertical lines moved per update (1..V_ACTIVE-STAR_H-1)
- FRAME_DIV, 1, number of frames per position update (1..255)
- BLINK_FRAMES, 8, length of the post-bounce blink window in frames (0..255)

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high
- HCount  in  10  horizontal pixel counter from sync generator
- VCount  in  10  vertical line counter from sync generator
- enable  in  1  1 = motion runs; 0 = freeze position and divider
- star_x_l  out  10  committed left edge of star
- star_y_t  out  10  committed top edge of star
- star_visible  out  1  gate for star_on (blink control)
- frame_tick  out  1  one-cycle pulse per frame start-of-blanking
- bounce  out  2  one-cycle pulse at commit; [0]=x edge hit, [1]=y edge hit
- busy  out  1  high while FSM is not IDLE

Behaviour:
- Derived limits: XMAX = H_ACTIVE-STAR_W (440); YMAX = V_ACTIVE-STAR_H (330). Positions are 10-bit unsigned and are never outside 0..XMAX / 0..YMAX.
- Reset values: star_x_l=X_INIT, star_y_t=Y_INIT, dir_x=+, dir_y=+, frame divider=0, blink counter=0, state=IDLE, star_visible=1, frame_tick=0, bounce=0, busy=0.
- Frame detect: cond = (VCount==V_ACTIVE && HCount==0). frame_tick is registered and is high in cycle N+1 when cond is true in cycle N and was false in cycle N-1. This tolerates counters that hold a value for several clocks.
- frame_tick always pulses, regardless of enable.
- Divider: on each frame_tick with enable=1, the divider increments. When it reaches FRAME_DIV-1 it clears to 0 and the FSM is launched.
- FSM states: IDLE, MOVE_X, MOVE_Y, COMMIT. Transitions:
  - IDLE→MOVE_X on launch.
  - MOVE_X→MOVE_Y, MOVE_Y→COMMIT, COMMIT→IDLE unconditionally.
  - busy = (state != IDLE).
- MOVE_X computes into shadow register nx:
  - dir + : if x+STEP_X >= XMAX then nx=XMAX, flip dir, set bx; else nx=x+STEP_X.
  - dir − : if x <= STEP_X then nx=0, flip dir, set bx; else nx=x−STEP_X.
  - Compare in 11 bits so no wrap-around can occur.
- MOVE_Y: same rule with y, STEP_Y, YMAX, by.
- COMMIT: star_x_l<=nx, star_y_t<=ny, bounce<={by,bx} for exactly one cycle. If bx|by, blink counter<=BLINK_FRAMES. Both axes bouncing in the same commit give a single reload and bounce=2'b11.
- Latency: with frame_tick in cycle N+1, states are MOVE_X at N+2, MOVE_Y at N+3, COMMIT at N+4. New position is visible from N+5.
- Blink: on each frame_tick, a nonzero blink counter decrements. star_visible = (blink==0) | ~blink[0].
  - A reload in the same cycle as a decrement wins.
  - The blink counter runs even when enable=0.
- enable=0: a launch is not issued, the divider holds, and an FSM already past IDLE finishes its sequence.
- A frame_tick while busy is ignored for launch but still counts for blink.
- Reset mid-sequence: all state returns to reset values in the next cycle. No partial commit occurs.

Test Plan:
- Reset with defaults → star_x_l=430, star_y_t=325, star_visible=1, busy=0. Drive counters to (HCount=0, VCount=480) → frame_tick one cycle later; star_x_l=432, star_y_t=326 exactly 4 cycles after frame_tick.
- Run 5 frames from reset → x: 432,434,436,438,440; y: 326..330. Frame 5 gives bounce=2'b11 for one cycle. Frame 6 gives x=438, y=329.
- After the frame-5 bounce → star_visible pattern over the next frame ticks (blink 8→0): 0,1,0,1,0,1,0,1 then constant 1.
- Hold cond true (HCount=0, VCount=480) for 10 clocks → exactly one frame_tick and one position update.
- FRAME_DIV=3, enable toggled low for 2 frames mid-run → position advances only on every 3rd enabled frame. Divider count resumes where it stopped.
- Assert reset in the MOVE_Y cycle → next cycle x=430, y=325, busy=0, bounce=0. No commit is observed.
- Left edge with X_INIT=3, STEP_X=2, dir forced − by a prior bounce → x: 1, then 0 with bx=1, then 2.
